// File: rtl/vga_text_scanner.sv
// vga_text_scanner: 640x480@60 VGA timing and 80x30 text-cell scan with a 3-stage pixel pipeline
module vga_text_scanner (
   input  logic        clk,
   input  logic        reset,
   output logic [11:0] VgaAddress,
   input  logic [7:0]  CharIn,
   input  logic [7:0]  ColorIn,
   output logic [11:0] FontAddr,
   input  logic [7:0]  FontRow,
   output logic        Hsync,
   output logic        Vsync,
   output logic [3:0]  VgaR,
   output logic [3:0]  VgaG,
   output logic [3:0]  VgaB,
   output logic        FrameStart
);
   localparam logic [1:0] DIV_MAX = 2'd3;
   localparam logic [9:0] H_VIS = 10'd640, H_SS = 10'd656, H_SE = 10'd752, H_MAX = 10'd799;
   localparam logic [9:0] V_VIS = 10'd480, V_SS = 10'd490, V_SE = 10'd492, V_MAX = 10'd524;
   logic [1:0] div;
   logic [9:0] h_cnt, v_cnt;
   logic       ptick, h_end, v_end, vis, hs0, vs0;
   logic [4:0] row;
   logic [7:0] char1, col1, col2, font2;
   logic [3:0] gl1;
   logic [2:0] bx1, bx2;
   logic       vis1, vis2, hs1, hs2, vs1, vs2, on;
   // hs*/vs* carry the sync pulse active-high so every pipeline register resets to 0
   always_comb begin
      ptick = div == DIV_MAX;
      h_end = h_cnt == H_MAX;
      v_end = v_cnt == V_MAX;
      vis   = (h_cnt < H_VIS) && (v_cnt < V_VIS);
      hs0   = (h_cnt >= H_SS) && (h_cnt < H_SE);
      vs0   = (v_cnt >= V_SS) && (v_cnt < V_SE);
      row   = v_cnt[8:4];
      VgaAddress = vis ? {1'b0, row, 6'b0} + {3'b0, row, 4'b0} + {5'b0, h_cnt[9:3]} : 12'd0;
      FontAddr   = {char1, gl1};
      on         = vis2 & font2[3'd7 - bx2];
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         div        <= 2'd0;
         h_cnt      <= 10'd0;
         v_cnt      <= 10'd0;
         FrameStart <= 1'b0;
      end else begin
         div        <= ptick ? 2'd0 : div + 2'd1;
         FrameStart <= ptick && h_end && v_end;
         if (ptick) begin
            h_cnt <= h_end ? 10'd0 : h_cnt + 10'd1;
            if (h_end) v_cnt <= v_end ? 10'd0 : v_cnt + 10'd1;
         end
      end
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         char1 <= 8'd0;
         col1  <= 8'd0;
         gl1   <= 4'd0;
         bx1   <= 3'd0;
         vis1  <= 1'b0;
         hs1   <= 1'b0;
         vs1   <= 1'b0;
         font2 <= 8'd0;
         col2  <= 8'd0;
         bx2   <= 3'd0;
         vis2  <= 1'b0;
         hs2   <= 1'b0;
         vs2   <= 1'b0;
         VgaR  <= 4'd0;
         VgaG  <= 4'd0;
         VgaB  <= 4'd0;
         Hsync <= 1'b1;
         Vsync <= 1'b1;
      end else if (ptick) begin
         char1 <= CharIn;
         col1  <= ColorIn;
         gl1   <= v_cnt[3:0];
         bx1   <= h_cnt[2:0];
         vis1  <= vis;
         hs1   <= hs0;
         vs1   <= vs0;
         font2 <= FontRow;
         col2  <= col1;
         bx2   <= bx1;
         vis2  <= vis1;
         hs2   <= hs1;
         vs2   <= vs1;
         VgaR  <= on ? {col2[7:5], col2[7]} : 4'd0;
         VgaG  <= on ? {col2[4:2], col2[4]} : 4'd0;
         VgaB  <= on ? {col2[1:0], col2[1:0]} : 4'd0;
         Hsync <= !hs2;
         Vsync <= !vs2;
      end
   end
endmodule
